hw_cpu_jtag_debug_host: RTL and testbench
=========================================

# hw_cpu_jtag_debug_host

Host-side initiator for the CPU's virtual-JTAG debug port. It converts a simple command handshake (2-bit IR + 38-bit DR word) into the full virtual-JTAG state sequence: UIR, CDR, SDR×38, UDR, RTI. It drives the `vji_*` signals that the debug module consumes, captures the 38-bit TDO readback, and returns it on a response handshake. It sits in the test/bring-up fabric and lets on-chip logic or a testbench exercise the debug module without a physical JTAG cable.

## Interface
- `TCK_HALF`, default 2: `clk` cycles per TCK half-period; legal range ≥1.
- `DR_W`, default 38: data-register length. The width is fixed by the debug module.
- `clk` in 1: system clock. This is the block's only clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_ir` in 2: IR value (0 OCIMEM, 1 TRACEMEM, 2 BREAK, 3 TRACECTRL).
- `cmd_dr` in 38: DR word, shifted out LSB first.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_dr` out 38: captured TDO bits; bit 0 is the first bit shifted.
- `rsp_ir` out 2: `vji_ir_out` sampled during UIR.
- `vji_tck` out 1: generated TCK.
- `vji_tdi` out 1: serial data to the debug module.
- `vji_tdo` in 1: serial data from the debug module.
- `vji_ir_in` out 2: IR presented to the debug module.
- `vji_ir_out` in 2: status IR returned by the debug module.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti` out 1 each: virtual-state indicators.

## Operation
- **TCK generator.**
  - Free-running divider. `vji_tck` toggles every `TCK_HALF` clk cycles.
  - Internal one-cycle strobes: `tck_rise` on the cycle `vji_tck` goes 0→1, `tck_fall` on 1→0.
- **FSM states:** IDLE, UIR, CDR, SDR, UDR, RTI. All transitions occur only on `tck_fall`.
- **IDLE.**
  - `cmd_ready = IDLE && !rsp_valid`.
  - On handshake, latch `cmd_ir` into `vji_ir_in` and `cmd_dr` into the shift register, and set `pending`.
  - At the next `tck_fall` with `pending` set, go to UIR.
- **UIR** lasts 1 TCK period, with `vji_uir`=1. Sample `vji_ir_out` into `rsp_ir` at `tck_rise`.
- **CDR** lasts 1 period, with `vji_cdr`=1.
- **SDR** lasts `DR_W` periods, with `vji_sdr`=1.
  - `vji_tdi` = shift[0].
  - At each `tck_rise`, shift right and insert `vji_tdo` at bit `DR_W-1`.
  - A 6-bit bit counter counts 0..37. Leave SDR at the `tck_fall` following the 38th rise.
- **UDR** lasts 1 period, with `vji_udr`=1.
- **RTI** lasts 1 period, with `vji_rti`=1.
  - At the `tck_fall` ending RTI: load `rsp_dr` from the shift register, set `rsp_valid`, clear `pending`, return to IDLE.
- **Response.** `rsp_valid` holds until `rsp_valid && rsp_ready`, then clears on the next clk. `rsp_dr` and `rsp_ir` stay stable while `rsp_valid` is set.
- **Output encoding.** All state indicators are one-hot and registered. `vji_tdi`=0 outside SDR. `vji_ir_in` holds its last command value outside a transaction.

## Timing
- **Reset values** (asynchronous, immediate):
  - 0: `vji_tck`, `vji_tdi`, `vji_ir_in`, all `vji_*` state outputs, `rsp_valid`, `rsp_dr`, `rsp_ir`, `pending`.
  - 1: `cmd_ready`.
  - FSM is in IDLE and the divider counter is 0.
- **Reset mid-transaction** aborts the transaction. No response is produced, and the next command starts cleanly from UIR.
- **Transaction length:** 42 TCK periods (1+1+38+1+1) from the UIR-entry fall to the RTI-exit fall. Acceptance-to-UIR adds ≤1 TCK period (`2*TCK_HALF` clk).
- **Edge alignment:** outputs change only on clk edges that coincide with `tck_fall`. `vji_tdo` is sampled only on `tck_rise`, so data is stable half a TCK period on each side.
- **Back-to-back commands:** a new command can be accepted the clk after the response handshake. There is no overlap: one outstanding transaction maximum.
- **Simultaneous events:** a response handshake and `cmd_valid` in the same cycle does not accept the command (`cmd_ready` is still 0).
- **`TCK_HALF`=1:** TCK is `clk`/2. All rules above still hold.

## Structure
- Package `hw_cpu_jtag_dbg_pkg` contains:
  - the FSM state enum;
  - IR constants `IR_OCIMEM`/`IR_TRACEMEM`/`IR_BREAK`/`IR_TRACECTRL`;
  - `DBG_DR_W`=38.
- Sub-module `hw_cpu_jtag_tck_gen` holds the divider and produces `vji_tck`, `tck_rise`, `tck_fall`.
- FSM, shift register and response registers live in the top module.

## Test plan
- **Reset and idle:** apply reset mid-SDR → all `vji_*` outputs 0 and `cmd_ready`=1 immediately; no `rsp_valid` follows.
- **Loopback:** tie `vji_tdo` to a 1-period-delayed `vji_tdi`, TCK_HALF=2, `cmd_dr`=38'h2A_5A5A_5A5A → `rsp_dr` = 38'h2A_5A5A_5A5A shifted left by 1 with bit0=0; `rsp_valid` rises 42 TCK periods (168 clk) after UIR entry.
- **State sequence:** `cmd_ir`=2 → one UIR period with `vji_ir_in`=2, one CDR, exactly 38 SDR periods (count rising TCK edges), one UDR, one RTI; indicators never overlap.
- **IR readback:** `vji_ir_out`=2'b11 held during UIR → `rsp_ir`=3.
- **Backpressure:** hold `rsp_ready`=0 for 100 clk → `rsp_valid` and `rsp_dr` stable, `cmd_ready`=0; release → new command accepted the following clk.
- **Minimum divider:** TCK_HALF=1, tdo forced to constant 1 → `rsp_dr`=38'h3F_FFFF_FFFF; transaction completes in 84 clk from UIR entry.

Source files
------------

// File: rtl/hw_cpu_jtag_dbg_pkg.sv
// Shared types and constants for the virtual-JTAG debug host.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hw_cpu_jtag_dbg_pkg;

   localparam int DBG_DR_W = 38;

   localparam logic [1:0] IR_OCIMEM    = 2'd0;
   localparam logic [1:0] IR_TRACEMEM  = 2'd1;
   localparam logic [1:0] IR_BREAK     = 2'd2;
   localparam logic [1:0] IR_TRACECTRL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI
   } dbg_state_e;

   // One-hot virtual-state indicators {uir, cdr, sdr, udr, rti}; IDLE drives none.
   function automatic logic [4:0] state_ind(input dbg_state_e s);
      logic [4:0] r;
      r = '0;
      case (s)
         ST_UIR:  r = 5'b10000;
         ST_CDR:  r = 5'b01000;
         ST_SDR:  r = 5'b00100;
         ST_UDR:  r = 5'b00010;
         ST_RTI:  r = 5'b00001;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hw_cpu_jtag_tck_gen.sv
// Free-running TCK divider: tck toggles every TCK_HALF clk cycles, with edge strobes.
// Latency: strobes are high in the cycle whose closing clk edge moves tck.
// Backpressure: none; runs continuously out of reset.
module hw_cpu_jtag_tck_gen #(
   parameter int TCK_HALF = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic tck_o,
   output logic tck_rise_o,
   output logic tck_fall_o
);
   localparam int CW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TCK_HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tck_q, tck_d;
   logic          wrap;

   // Half-period counter; tck flips when it wraps.
   always_comb begin
      wrap  = (cnt_q == CNT_MAX);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      tck_d = wrap ? ~tck_q : tck_q;
   end

   // Divider state registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

   assign tck_o      = tck_q;
   assign tck_rise_o = wrap & ~tck_q;
   assign tck_fall_o = wrap &  tck_q;

endmodule

// File: rtl/hw_cpu_jtag_debug_host.sv
// Virtual-JTAG debug host: runs UIR, CDR, SDR x DR_W, UDR, RTI per command and returns captured TDO.
// Latency: <=1 TCK period to UIR entry, then 42 TCK periods to rsp_valid_o (TCK period = 2*TCK_HALF clk).
// Backpressure: one transaction in flight; cmd_ready_o stays low until the response is consumed.
module hw_cpu_jtag_debug_host
   import hw_cpu_jtag_dbg_pkg::*;
#(
   parameter int TCK_HALF = 2,
   parameter int DR_W     = DBG_DR_W
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic [1:0]      cmd_ir_i,
   input  logic [DR_W-1:0] cmd_dr_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DR_W-1:0] rsp_dr_o,
   output logic [1:0]      rsp_ir_o,
   output logic            vji_tck_o,
   output logic            vji_tdi_o,
   input  logic            vji_tdo_i,
   output logic [1:0]      vji_ir_in_o,
   input  logic [1:0]      vji_ir_out_i,
   output logic            vji_uir_o,
   output logic            vji_cdr_o,
   output logic            vji_sdr_o,
   output logic            vji_udr_o,
   output logic            vji_rti_o
);
   localparam int BC_W = 6;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_W);

   logic            tck_rise, tck_fall;
   dbg_state_e      state_q, state_d;
   logic            pending_q, pending_d;
   logic [DR_W-1:0] shift_q, shift_d;
   logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DR_W-1:0] rsp_dr_q, rsp_dr_d;
   logic [1:0]      rsp_ir_q, rsp_ir_d;
   logic [1:0]      ir_in_q, ir_in_d;
   logic            tdi_q, tdi_d;
   logic [4:0]      ind_q, ind_d;
   logic            cmd_hs;

   hw_cpu_jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .tck_o      (vji_tck_o),
      .tck_rise_o (tck_rise),
      .tck_fall_o (tck_fall)
   );

   // Pending is included so an accepted-but-not-started command cannot be overwritten.
   assign cmd_ready_o = (state_q == ST_IDLE) && !rsp_valid_q && !pending_q;
   assign cmd_hs      = cmd_valid_i && cmd_ready_o;

   // Next-state logic: every state change lines up with a falling TCK edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (tck_fall && pending_q)                state_d = ST_UIR;
         ST_UIR:  if (tck_fall)                             state_d = ST_CDR;
         ST_CDR:  if (tck_fall)                             state_d = ST_SDR;
         ST_SDR:  if (tck_fall && (bit_cnt_q == BC_LAST))   state_d = ST_UDR;
         ST_UDR:  if (tck_fall)                             state_d = ST_RTI;
         ST_RTI:  if (tck_fall)                             state_d = ST_IDLE;
         default:                                           state_d = ST_IDLE;
      endcase
   end

   // Datapath: command latch, IR/TDO capture on rising TCK, outputs updated on falling TCK.
   always_comb begin
      pending_d   = pending_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dr_d    = rsp_dr_q;
      rsp_ir_d    = rsp_ir_q;
      ir_in_d     = ir_in_q;
      tdi_d       = tdi_q;
      ind_d       = ind_q;

      if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;

      if (cmd_hs) begin
         ir_in_d   = cmd_ir_i;
         shift_d   = cmd_dr_i;
         pending_d = 1'b1;
      end

      if (tck_rise && (state_q == ST_UIR)) rsp_ir_d = vji_ir_out_i;

      if (state_q == ST_CDR) bit_cnt_d = '0;

      if (tck_rise && (state_q == ST_SDR)) begin
         shift_d   = {vji_tdo_i, shift_q[DR_W-1:1]};
         bit_cnt_d = bit_cnt_q + 1'b1;
      end

      if (tck_fall && (state_q == ST_RTI)) begin
         rsp_dr_d    = shift_q;
         rsp_valid_d = 1'b1;
         pending_d   = 1'b0;
      end

      // No rise can coincide with a fall, so shift_q[0] is the bit for the coming period.
      if (tck_fall) begin
         ind_d = state_ind(state_d);
         tdi_d = (state_d == ST_SDR) ? shift_q[0] : 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dr_q    <= '0;
         rsp_ir_q    <= '0;
         ir_in_q     <= '0;
         tdi_q       <= 1'b0;
         ind_q       <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dr_q    <= rsp_dr_d;
         rsp_ir_q    <= rsp_ir_d;
         ir_in_q     <= ir_in_d;
         tdi_q       <= tdi_d;
         ind_q       <= ind_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dr_o    = rsp_dr_q;
   assign rsp_ir_o    = rsp_ir_q;
   assign vji_ir_in_o = ir_in_q;
   assign vji_tdi_o   = tdi_q;
   assign {vji_uir_o, vji_cdr_o, vji_sdr_o, vji_udr_o, vji_rti_o} = ind_q;

endmodule

// File: tb/tb_hw_cpu_jtag_debug_host.sv
// Bench for the virtual-JTAG debug host: random commands, a debug-module responder and a response scoreboard.
// Latency: expects UIR within 2*TCK_HALF clk of acceptance and rsp_valid 42 TCK periods after UIR entry.
// Backpressure: randomly delays rsp_ready, including long stalls, and checks responses hold steady.
module tb_hw_cpu_jtag_debug_host;
   import hw_cpu_jtag_dbg_pkg::*;

   localparam int DW   = DBG_DR_W;
   localparam int NTXN = 12;
   localparam logic [DW-1:0] ONES = {DW{1'b1}};

   typedef struct {
      logic [1:0]    ir;
      logic [DW-1:0] dr;
      logic [DW-1:0] exp_dr;
      logic [DW-1:0] pat;
      logic [1:0]    irout;
      bit            loopback;
      bit            stall;
   } txn_t;

   logic clk;
   logic rst, rst2;
   logic cmd_valid, cmd_ready, rsp_valid, rsp_ready;
   logic [1:0] cmd_ir, rsp_ir, ir_in, ir_out;
   logic [DW-1:0] cmd_dr, rsp_dr;
   logic tck, tdi, tdo, uir, cdr, sdr, udr, rti;
   logic cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2;
   logic [1:0] cmd_ir2, rsp_ir2, ir_in2, ir_out2;
   logic [DW-1:0] cmd_dr2, rsp_dr2;
   logic tck2, tdi2, tdo2, uir2, cdr2, sdr2, udr2, rti2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int uir_cyc = 0, last_accept_cyc = 0, hs_cyc = 0, nrsp = 0;
   bit done2 = 0;
   txn_t sbq[$];
   txn_t stq[$];
   txn_t cur;
   int obs_cnt[5];
   bit obs_overlap;
   logic [DW-1:0] obs_tdi;
   logic [1:0] obs_irin;
   logic per_tdi;
   logic [1:0] irs [4] = '{IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL};

   hw_cpu_jtag_debug_host #(.TCK_HALF(2)) dut (
      .clk_i(clk), .reset_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_ir_i(cmd_ir), .cmd_dr_i(cmd_dr), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_dr_o(rsp_dr), .rsp_ir_o(rsp_ir), .vji_tck_o(tck), .vji_tdi_o(tdi), .vji_tdo_i(tdo),
      .vji_ir_in_o(ir_in), .vji_ir_out_i(ir_out), .vji_uir_o(uir), .vji_cdr_o(cdr),
      .vji_sdr_o(sdr), .vji_udr_o(udr), .vji_rti_o(rti)
   );

   hw_cpu_jtag_debug_host #(.TCK_HALF(1)) dut2 (
      .clk_i(clk), .reset_i(rst2), .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2),
      .cmd_ir_i(cmd_ir2), .cmd_dr_i(cmd_dr2), .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2),
      .rsp_dr_o(rsp_dr2), .rsp_ir_o(rsp_ir2), .vji_tck_o(tck2), .vji_tdi_o(tdi2), .vji_tdo_i(tdo2),
      .vji_ir_in_o(ir_in2), .vji_ir_out_i(ir_out2), .vji_uir_o(uir2), .vji_cdr_o(cdr2),
      .vji_sdr_o(sdr2), .vji_udr_o(udr2), .vji_rti_o(rti2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_dr();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[DW-1:0];
   endfunction

   // Debug-module responder: tracks the state sequence, records TDI, drives TDO and IR status.
   initial begin : observer
      logic ptck, puir;
      ptck = 0; puir = 0; tdo = 0; ir_out = 0; per_tdi = 0;
      cur.loopback = 0; cur.pat = '0; cur.irout = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ptck = 0; puir = 0;
            continue;
         end
         if ($countones({uir, cdr, sdr, udr, rti}) > 1) obs_overlap = 1;
         if (uir && !puir) begin
            uir_cyc = cyc;
            foreach (obs_cnt[i]) obs_cnt[i] = 0;
            obs_overlap = 0;
            obs_tdi = '0;
            obs_irin = ir_in;
            chk("accept_to_uir", 64'((cyc - last_accept_cyc) inside {[1:4]}), 64'd1);
            if (stq.size() > 0) cur = stq.pop_front();
            else begin
               cur.loopback = 0; cur.pat = rnd_dr(); cur.irout = '0;
            end
            ir_out = cur.irout;
         end
         if (tck && !ptck) begin
            if (uir) obs_cnt[0]++;
            if (cdr) obs_cnt[1]++;
            if (sdr) begin
               if (obs_cnt[2] < DW) obs_tdi[obs_cnt[2]] = tdi;
               obs_cnt[2]++;
            end
            if (udr) obs_cnt[3]++;
            if (rti) obs_cnt[4]++;
            per_tdi = tdi;
         end
         if (!tck && ptck) begin
            if (cur.loopback) tdo = per_tdi;
            else if (sdr && obs_cnt[2] < DW) tdo = cur.pat[obs_cnt[2]];
            else tdo = 1'($urandom);
         end
         ptck = tck;
         puir = uir;
      end
   end

   // Response monitor: pops the scoreboard on each new response and drives rsp_ready.
   initial begin : monitor
      txn_t e;
      int hold, wcnt;
      bit in_rsp, unstable;
      logic [DW-1:0] snap_dr;
      logic [1:0] snap_ir;
      rsp_ready = 0; in_rsp = 0; hold = 0; wcnt = 0; unstable = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rsp_ready = 0; in_rsp = 0;
            continue;
         end
         if (rsp_valid) begin
            if (!in_rsp) begin
               in_rsp = 1; wcnt = 0; unstable = 0;
               snap_dr = rsp_dr; snap_ir = rsp_ir;
               chk("rsp_latency", 64'(cyc - uir_cyc), 64'd168);
               if (sbq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_rsp: got rsp_dr=%0h, expected no response", rsp_dr);
                  hold = 0;
               end else begin
                  e = sbq.pop_front();
                  chk("rsp_dr", 64'(rsp_dr), 64'(e.exp_dr));
                  chk("rsp_ir", 64'(rsp_ir), 64'(e.irout));
                  chk("ir_in_at_uir", 64'(obs_irin), 64'(e.ir));
                  chk("tdi_stream", 64'(obs_tdi), 64'(e.dr));
                  chk("state_periods", {8'(obs_cnt[0]), 8'(obs_cnt[1]), 8'(obs_cnt[2]), 8'(obs_cnt[3]), 8'(obs_cnt[4])},
                      {8'd1, 8'd1, 8'(DW), 8'd1, 8'd1});
                  chk("ind_overlap", 64'(obs_overlap), 64'd0);
                  hold = e.stall ? 100 : $urandom_range(0, 3);
               end
            end
            if (rsp_dr !== snap_dr || rsp_ir !== snap_ir || cmd_ready !== 1'b0) unstable = 1;
            rsp_ready = (wcnt >= hold);
            if (rsp_ready) hs_cyc = cyc + 1;
            wcnt++;
         end else begin
            if (in_rsp) begin
               chk("rsp_stable", 64'(unstable), 64'd0);
               in_rsp = 0;
               nrsp++;
            end
            rsp_ready = 0;
         end
      end
   end

   // Second instance at the minimum divider with TDO held high.
   initial begin : min_div
      int t0;
      bit ok;
      rst2 = 1; cmd_valid2 = 0; cmd_ir2 = 0; cmd_dr2 = 0; rsp_ready2 = 1; tdo2 = 1; ir_out2 = 2'b11;
      repeat (3) @(negedge clk);
      rst2 = 0;
      chk("min_cmd_ready", 64'(cmd_ready2), 64'd1);
      cmd_ir2 = IR_TRACECTRL; cmd_dr2 = rnd_dr(); cmd_valid2 = 1;
      @(negedge clk);
      cmd_valid2 = 0;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (uir2) begin ok = 1; break; end
         @(negedge clk);
      end
      chk("min_uir_seen", 64'(ok), 64'd1);
      t0 = cyc;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (rsp_valid2) begin ok = 1; break; end
         @(negedge clk);
      end
      chk("min_rsp_seen", 64'(ok), 64'd1);
      chk("min_latency", 64'(cyc - t0), 64'd84);
      chk("min_rsp_dr", 64'(rsp_dr2), 64'(ONES));
      chk("min_rsp_ir", 64'(rsp_ir2), 64'd3);
      done2 = 1;
   end

   // Command driver: reset checks, mid-transaction abort, then the random command stream.
   initial begin : driver
      bit got, ok;
      txn_t t;
      rst = 1; cmd_valid = 0; cmd_ir = 0; cmd_dr = 0;
      repeat (3) @(negedge clk);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("reset_vji", 64'({tck, tdi, ir_in, uir, cdr, sdr, udr, rti}), 64'd0);
      chk("reset_rsp", 64'({rsp_valid, rsp_ir, rsp_dr}), 64'd0);
      @(negedge clk);
      rst = 0;

      cmd_ir = IR_TRACEMEM; cmd_dr = rnd_dr(); cmd_valid = 1;
      last_accept_cyc = cyc + 1;
      @(negedge clk);
      cmd_valid = 0;
      for (int i = 0; i < 400 && !sdr; i++) @(negedge clk);
      chk("abort_reached_sdr", 64'(sdr), 64'd1);
      repeat (25) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("abort_vji", 64'({tck, tdi, ir_in, uir, cdr, sdr, udr, rti}), 64'd0);
      chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      rst = 0;
      got = 0;
      repeat (300) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      chk("abort_no_rsp", 64'(got), 64'd0);

      for (int n = 0; n < NTXN; n++) begin
         t.ir = irs[$urandom_range(0, 3)];
         t.dr = rnd_dr();
         t.pat = rnd_dr();
         t.irout = 2'($urandom);
         t.loopback = (n % 3 == 1);
         t.stall = (n == 4) || (n == 9);
         if (n == 2) begin
            t.ir = IR_BREAK; t.dr = 38'h2A_5A5A_5A5A; t.loopback = 1; t.irout = 2'b11;
         end
         // Loopback returns the previous period's TDI, so the word comes back one bit up with a 0 first.
         t.exp_dr = t.loopback ? (t.dr << 1) : t.pat;
         cmd_ir = t.ir; cmd_dr = t.dr; cmd_valid = 1;
         ok = 0;
         for (int i = 0; i < 3000; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
         end
         if (!ok) begin
            chk("cmd_accept_timeout", 64'(ok), 64'd1);
            break;
         end
         last_accept_cyc = cyc + 1;
         sbq.push_back(t);
         stq.push_back(t);
         if (n > 0) chk("b2b_accept", 64'(last_accept_cyc), 64'(hs_cyc + 1));
         @(negedge clk);
         cmd_valid = 0;
         cmd_dr = rnd_dr();
      end

      for (int i = 0; i < 6000 && nrsp < NTXN; i++) @(negedge clk);
      chk("all_responses", 64'(nrsp), 64'(NTXN));
      for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
      chk("min_div_done", 64'(done2), 64'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
